// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// slave = the controller, master = the pipeline driving hazard sources.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ARS1_ID;
  logic [4:0]       ARS2_ID;
  logic             USES_RS1_ID;
  logic             USES_RS2_ID;
  logic             MEMREAD_EX;
  logic [4:0]       ARD_EX;
  logic             BRANCH_TAKEN_EX;
  logic             DMEM_REQ;
  logic             DMEM_READY;
  logic             PC_WRITE;
  logic             IF_ID_WRITE;
  logic             ID_EX_WRITE;
  logic             EX_MEM_WRITE;
  logic             IF_ID_FLUSH;
  logic             ID_EX_FLUSH;
  logic             MEM_WB_FLUSH;
  logic [1:0]       STATE;
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;

  modport master (
    output ARS1_ID, ARS2_ID, USES_RS1_ID, USES_RS2_ID, MEMREAD_EX, ARD_EX,
           BRANCH_TAKEN_EX, DMEM_REQ, DMEM_READY,
    input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
           IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, STATE, STALL_CNT, FLUSH_CNT
  );

  modport slave (
    input  ARS1_ID, ARS2_ID, USES_RS1_ID, USES_RS2_ID, MEMREAD_EX, ARD_EX,
           BRANCH_TAKEN_EX, DMEM_REQ, DMEM_READY,
    output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
           IF_ID_FLUSH, ID_EX_FLUSH, MEM_WB_FLUSH, STATE, STALL_CNT, FLUSH_CNT
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, branch flushes, dmem wait freeze.
// Controls are Mealy (0 cycles); stall/flush counters update on the clock edge.
module pipe_hazard_ctrl #(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                clk,
  input  logic                rst,
  pipe_hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    MEM_WAIT = 2'b10
  } state_t;

  localparam logic [1:0] LU_REM = 2'(LU_STALL_CYCLES - 1);

  state_t           state_q, state_d, ret_q, ret_d, eff;
  logic [1:0]       rem_q, rem_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             lu, mw, flush_evt;
  logic             pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic             if_id_flush, id_ex_flush, mem_wb_flush;

  assign lu = hz.MEMREAD_EX && (hz.ARD_EX != 5'd0) &&
              ((hz.USES_RS1_ID && (hz.ARS1_ID == hz.ARD_EX)) ||
               (hz.USES_RS2_ID && (hz.ARS2_ID == hz.ARD_EX)));
  // A dropped request while waiting counts as completion.
  assign mw = hz.DMEM_REQ && !hz.DMEM_READY;

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    flush_evt    = 1'b0;
    state_d      = RUN;
    ret_d        = RUN;
    rem_d        = rem_q;
    // In MEM_WAIT the saved state's rules apply once memory is ready.
    eff          = (state_q == MEM_WAIT) ? ret_q : state_q;

    if (mw) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = MEM_WAIT;
      ret_d        = eff;
    end else if (hz.BRANCH_TAKEN_EX) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      flush_evt   = 1'b1;
      rem_d       = 2'd0;
    end else if (eff == LU_STALL) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (rem_q <= 2'd1) begin
        rem_d = 2'd0;
      end else begin
        rem_d   = rem_q - 2'd1;
        state_d = LU_STALL;
      end
    end else if (lu) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      if (LU_STALL_CYCLES > 1) begin
        rem_d   = LU_REM;
        state_d = LU_STALL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      rem_q       <= 2'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      rem_q   <= rem_d;
      if (!pc_write && !(&stall_cnt_q))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_evt && !(&flush_cnt_q))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Reset forces every control low immediately, without waiting for an edge.
  assign hz.PC_WRITE     = pc_write     && !rst;
  assign hz.IF_ID_WRITE  = if_id_write  && !rst;
  assign hz.ID_EX_WRITE  = id_ex_write  && !rst;
  assign hz.EX_MEM_WRITE = ex_mem_write && !rst;
  assign hz.IF_ID_FLUSH  = if_id_flush  && !rst;
  assign hz.ID_EX_FLUSH  = id_ex_flush  && !rst;
  assign hz.MEM_WB_FLUSH = mem_wb_flush && !rst;
  assign hz.STATE        = state_q;
  assign hz.STALL_CNT    = stall_cnt_q;
  assign hz.FLUSH_CNT    = flush_cnt_q;

endmodule
